// File: rtl/controlador_memoria_datos_pkg.sv
// rtl/controlador_memoria_datos_pkg.sv - access-size encodings and FSM states for the data-memory controller
package controlador_memoria_datos_pkg;

  localparam logic [1:0] TAM_BYTE      = 2'b00;
  localparam logic [1:0] TAM_MEDIA     = 2'b01;
  localparam logic [1:0] TAM_PALABRA   = 2'b10;
  localparam logic [1:0] TAM_RESERVADO = 2'b11;

  typedef enum logic [2:0] {
    INACTIVO  = 3'd0,
    LEER      = 3'd1,
    MODIFICAR = 3'd2,
    ESCRIBIR  = 3'd3,
    RESPUESTA = 3'd4
  } estado_t;

endpackage

// File: rtl/controlador_memoria_datos_if.sv
// rtl/controlador_memoria_datos_if.sv - MEM-stage request/response bus between pipeline and controller
interface controlador_memoria_datos_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_tam;
  logic        req_sinsigno;
  logic [31:0] req_dir;
  logic [31:0] req_dato;
  logic        resp_valid;
  logic [31:0] resp_dato;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_tam, req_sinsigno, req_dir, req_dato,
    input  req_ready, resp_valid, resp_dato, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_tam, req_sinsigno, req_dir, req_dato,
    output req_ready, resp_valid, resp_dato, resp_err
  );

endinterface

// File: rtl/controlador_memoria_datos_extensor_carga.sv
// rtl/controlador_memoria_datos_extensor_carga.sv - load lane select with sign/zero extension
module controlador_memoria_datos_extensor_carga
  import controlador_memoria_datos_pkg::*;
(
  input  logic [31:0] palabra_i,
  input  logic [1:0]  dir_i,
  input  logic [1:0]  tam_i,
  input  logic        sinsigno_i,
  output logic [31:0] dato_o
);

  logic [7:0]  byte_sel;
  logic [15:0] media_sel;

  always_comb begin
    byte_sel  = palabra_i[{dir_i, 3'b000} +: 8];
    media_sel = palabra_i[{dir_i[1], 4'b0000} +: 16];
    case (tam_i)
      TAM_BYTE:  dato_o = {{24{byte_sel[7] & ~sinsigno_i}}, byte_sel};
      TAM_MEDIA: dato_o = {{16{media_sel[15] & ~sinsigno_i}}, media_sel};
      default:   dato_o = palabra_i;
    endcase
  end

endmodule

// File: rtl/controlador_memoria_datos.sv
// rtl/controlador_memoria_datos.sv - MEM-stage initiator for the word-organised data RAM
// Sub-word stores are done as read-modify-write since the RAM only writes whole words.
module controlador_memoria_datos
  import controlador_memoria_datos_pkg::*;
#(
  parameter int ANCHO_DIR   = 10,
  parameter int ANCHO_DATOS = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  controlador_memoria_datos_if.slave bus,
  output logic                   mem_read_o,
  output logic                   mem_write_o,
  output logic [ANCHO_DIR-1:0]   mem_dir_o,
  output logic [ANCHO_DATOS-1:0] mem_din_o,
  input  logic [ANCHO_DATOS-1:0] mem_dout_i
);

  estado_t              estado_q;
  logic                 we_q;
  logic [1:0]           tam_q;
  logic                 sinsigno_q;
  logic [1:0]           byte_q;
  logic [31:0]          dato_q;
  logic [31:0]          palabra_q;
  logic                 ready_q;
  logic                 resp_valid_q;
  logic                 resp_err_q;
  logic [31:0]          resp_dato_q;
  logic                 mem_read_q;
  logic                 mem_write_q;
  logic [ANCHO_DIR-1:0] mem_dir_q;
  logic [31:0]          mem_din_q;

  logic                 error_d;
  logic [31:0]          merge_d;
  logic [31:0]          carga_d;

  always_comb begin
    error_d = (bus.req_tam == TAM_RESERVADO)
            || ((bus.req_tam == TAM_MEDIA) && bus.req_dir[0])
            || ((bus.req_tam == TAM_PALABRA) && (bus.req_dir[1:0] != 2'b00))
            || (|bus.req_dir[31:ANCHO_DIR+2]);
  end

  // Only the addressed lane(s) are replaced; the rest keep the word just read.
  always_comb begin
    merge_d = palabra_q;
    case (tam_q)
      TAM_BYTE:  merge_d[{byte_q, 3'b000} +: 8]     = dato_q[7:0];
      TAM_MEDIA: merge_d[{byte_q[1], 4'b0000} +: 16] = dato_q[15:0];
      default:   merge_d = dato_q;
    endcase
  end

  controlador_memoria_datos_extensor_carga u_extensor (
    .palabra_i  (mem_dout_i),
    .dir_i      (byte_q),
    .tam_i      (tam_q),
    .sinsigno_i (sinsigno_q),
    .dato_o     (carga_d)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      estado_q     <= INACTIVO;
      we_q         <= 1'b0;
      tam_q        <= TAM_BYTE;
      sinsigno_q   <= 1'b0;
      byte_q       <= 2'b00;
      dato_q       <= '0;
      palabra_q    <= '0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_dato_q  <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_dir_q    <= '0;
      mem_din_q    <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      case (estado_q)
        INACTIVO: begin
          if (bus.req_valid) begin
            ready_q     <= 1'b0;
            we_q        <= bus.req_we;
            tam_q       <= bus.req_tam;
            sinsigno_q  <= bus.req_sinsigno;
            byte_q      <= bus.req_dir[1:0];
            dato_q      <= bus.req_dato;
            mem_dir_q   <= bus.req_dir[ANCHO_DIR+1:2];
            resp_dato_q <= '0;
            if (error_d) begin
              estado_q     <= RESPUESTA;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else if (bus.req_we && (bus.req_tam == TAM_PALABRA)) begin
              estado_q    <= ESCRIBIR;
              mem_write_q <= 1'b1;
              mem_din_q   <= bus.req_dato;
            end else begin
              estado_q   <= LEER;
              mem_read_q <= 1'b1;
            end
          end
        end
        LEER: begin
          // The RAM latched dout on the negedge inside this cycle.
          palabra_q <= mem_dout_i;
          if (we_q) begin
            estado_q <= MODIFICAR;
          end else begin
            estado_q     <= RESPUESTA;
            resp_valid_q <= 1'b1;
            resp_dato_q  <= carga_d;
          end
        end
        MODIFICAR: begin
          estado_q    <= ESCRIBIR;
          mem_write_q <= 1'b1;
          mem_din_q   <= merge_d;
        end
        ESCRIBIR: begin
          estado_q     <= RESPUESTA;
          resp_valid_q <= 1'b1;
        end
        RESPUESTA: begin
          estado_q    <= INACTIVO;
          ready_q     <= 1'b1;
          resp_dato_q <= '0;
        end
        default: begin
          estado_q <= INACTIVO;
          ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_dato  = resp_dato_q;
  assign mem_read_o     = mem_read_q;
  assign mem_write_o    = mem_write_q;
  assign mem_dir_o      = mem_dir_q;
  assign mem_din_o      = mem_din_q;

endmodule

// File: tb/tb_controlador_memoria_datos.sv
// tb/tb_controlador_memoria_datos.sv - bench for controlador_memoria_datos with a negedge word RAM
module tb_controlador_memoria_datos;
  import controlador_memoria_datos_pkg::*;

  localparam int AD = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  controlador_memoria_datos_if bus();
  logic          mem_read, mem_write;
  logic [AD-1:0] mem_dir;
  logic [31:0]   mem_din, mem_dout;

  controlador_memoria_datos #(.ANCHO_DIR(AD), .ANCHO_DATOS(32)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus),
    .mem_read_o  (mem_read),
    .mem_write_o (mem_write),
    .mem_dir_o   (mem_dir),
    .mem_din_o   (mem_din),
    .mem_dout_i  (mem_dout)
  );

  // Data memory: latches on negedge, every word starts at 0x00000004.
  logic [31:0] ram [0:(1<<AD)-1];
  logic        ram_clear;
  logic        ambos;
  always @(negedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < (1<<AD); i++) ram[i] <= 32'h4;
      ambos <= 1'b0;
    end else begin
      if (mem_read)  mem_dout <= ram[mem_dir];
      if (mem_write) ram[mem_dir] <= mem_din;
      if (mem_read && mem_write) ambos <= 1'b1;
    end
  end

  int vectores = 0;
  int fallos   = 0;
  logic [31:0] ref_mem [0:(1<<AD)-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectores++;
    assert (obs === exp) else begin
      fallos++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Behavioural model: byte-addressed little-endian memory.
  task automatic modelo(input bit we, input bit [1:0] tam, input bit uns, input bit [31:0] dir,
                        input bit [31:0] dato, output bit err, output bit [31:0] rd,
                        output int lat, output int nr, output int nw, output bit [31:0] wword);
    int sz, sh;
    bit [31:0] w, mask;
    err = (tam == 2'd3) || (dir >= 32'd4096) || (tam == 2'd1 && dir % 2 != 0)
       || (tam == 2'd2 && dir % 4 != 0);
    rd = 0; nr = 0; nw = 0; wword = 0; lat = 1;
    if (err) return;
    sz   = (tam == 2'd0) ? 1 : (tam == 2'd1) ? 2 : 4;
    sh   = 8 * int'(dir % 4);
    w    = ref_mem[dir[11:2]];
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 32'h1);
    if (we) begin
      wword = (w & ~(mask << sh)) | ((dato & mask) << sh);
      ref_mem[dir[11:2]] = wword;
      nw  = 1;
      nr  = (sz == 4) ? 0 : 1;
      lat = (sz == 4) ? 2 : 4;
    end else begin
      rd = (w >> sh) & mask;
      if (sz < 4 && !uns && rd[8*sz-1]) rd = rd | ~mask;
      nr  = 1;
      lat = 2;
    end
  endtask

  task automatic presentar(input bit we, input bit [1:0] tam, input bit uns,
                           input bit [31:0] dir, input bit [31:0] dato);
    bus.req_we = we; bus.req_tam = tam; bus.req_sinsigno = uns;
    bus.req_dir = dir; bus.req_dato = dato;
  endtask

  task automatic hacer(input string tag, input bit we, input bit [1:0] tam, input bit uns,
                       input bit [31:0] dir, input bit [31:0] dato);
    bit        e_err;
    bit [31:0] e_rd, e_w;
    int        e_lat, e_nr, e_nw, lat, nr, nw;
    bit        visto;
    @(negedge clk);
    chk({tag, ":ready_in"}, bus.req_ready, 1);
    presentar(we, tam, uns, dir, dato);
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    modelo(we, tam, uns, dir, dato, e_err, e_rd, e_lat, e_nr, e_nw, e_w);
    bus.req_valid = 1'b0;
    presentar(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom);
    lat = 0; nr = 0; nw = 0; visto = 0;
    while (!visto && lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.resp_valid) visto = 1;
      else begin
        chk({tag, ":busy"}, bus.req_ready, 0);
        if (mem_read) begin
          nr++;
          chk({tag, ":rdir"}, 32'(mem_dir), 32'(dir[11:2]));
        end
        if (mem_write) begin
          nw++;
          chk({tag, ":wdir"}, 32'(mem_dir), 32'(dir[11:2]));
          chk({tag, ":din"}, mem_din, e_w);
        end
      end
    end
    chk({tag, ":resp"}, 32'(visto), 1);
    chk({tag, ":lat"}, lat, e_lat);
    chk({tag, ":err"}, 32'(bus.resp_err), 32'(e_err));
    chk({tag, ":dato"}, bus.resp_dato, e_rd);
    chk({tag, ":nread"}, nr, e_nr);
    chk({tag, ":nwrite"}, nw, e_nw);
    @(negedge clk);
    chk({tag, ":ready_out"}, bus.req_ready, 1);
    chk({tag, ":pulse"}, bus.resp_valid, 0);
  endtask

  initial begin
    bit [31:0] bq_dir [3];
    bit [1:0]  bq_tam [3];
    bit        bq_we  [3];
    bit [31:0] bq_dat [3];
    bit [31:0] exp_d [$];
    bit        exp_e [$];
    bit        e_err, acepta;
    bit [31:0] e_rd, e_w, dir;
    int        e_lat, e_nr, e_nw, idx, nresp, nacc;
    bit [1:0]  tam;

    for (int i = 0; i < (1<<AD); i++) ref_mem[i] = 32'h4;
    rst = 1'b1; ram_clear = 1'b1; bus.req_valid = 1'b0;
    presentar(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0; ram_clear = 1'b0;
    @(negedge clk);
    chk("rst:ready", bus.req_ready, 1);
    chk("rst:resp_valid", bus.resp_valid, 0);
    chk("rst:resp_err", bus.resp_err, 0);
    chk("rst:resp_dato", bus.resp_dato, 0);
    chk("rst:mem_read", mem_read, 0);
    chk("rst:mem_write", mem_write, 0);
    chk("rst:mem_dir", 32'(mem_dir), 0);
    chk("rst:mem_din", mem_din, 0);

    hacer("lw0", 0, TAM_PALABRA, 0, 32'h0, 0);
    hacer("sb5", 1, TAM_BYTE, 0, 32'h5, 32'h0000_00AB);
    hacer("lw4", 0, TAM_PALABRA, 0, 32'h4, 0);
    chk("lw4:abs", ref_mem[1], 32'h0000_AB04);
    hacer("sw8", 1, TAM_PALABRA, 0, 32'h8, 32'h0000_0080);
    hacer("lb8", 0, TAM_BYTE, 0, 32'h8, 0);
    hacer("lbu8", 0, TAM_BYTE, 1, 32'h8, 0);
    hacer("lh8", 0, TAM_MEDIA, 0, 32'h8, 0);
    hacer("err_lw6", 0, TAM_PALABRA, 0, 32'h6, 0);
    hacer("err_sh3", 1, TAM_MEDIA, 0, 32'h3, 32'h1234);
    hacer("err_lw1000", 0, TAM_PALABRA, 0, 32'h1000, 0);
    hacer("err_tam3", 0, TAM_RESERVADO, 0, 32'h0, 0);

    // Reset while the SH sits in MODIFICAR: no write, no response.
    @(negedge clk);
    presentar(1, TAM_MEDIA, 0, 32'h10, 32'h0000_BEEF);
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rmw:read", mem_read, 1);
    @(negedge clk);
    chk("rmw:nowrite", mem_write, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rmw:ready", bus.req_ready, 1);
    chk("rmw:resp_valid", bus.resp_valid, 0);
    chk("rmw:mem_write", mem_write, 0);
    repeat (3) begin
      @(negedge clk);
      chk("rmw:quiet", {30'b0, bus.resp_valid, mem_write}, 0);
    end
    hacer("lw10", 0, TAM_PALABRA, 0, 32'h10, 0);
    chk("lw10:abs", ref_mem[4], 32'h4);

    // Back-to-back with req_valid held high.
    bq_we[0] = 1; bq_tam[0] = TAM_MEDIA;   bq_dir[0] = 32'h20; bq_dat[0] = 32'h1234;
    bq_we[1] = 0; bq_tam[1] = TAM_PALABRA; bq_dir[1] = 32'h20; bq_dat[1] = 0;
    bq_we[2] = 0; bq_tam[2] = TAM_BYTE;    bq_dir[2] = 32'h21; bq_dat[2] = 0;
    idx = 0; nresp = 0; nacc = 0;
    @(negedge clk);
    presentar(bq_we[0], bq_tam[0], 0, bq_dir[0], bq_dat[0]);
    bus.req_valid = 1'b1;
    for (int c = 0; c < 60 && nresp < 3; c++) begin
      acepta = bus.req_ready && bus.req_valid;
      @(posedge clk); #1;
      if (acepta) begin
        modelo(bq_we[idx], bq_tam[idx], 0, bq_dir[idx], bq_dat[idx], e_err, e_rd, e_lat, e_nr, e_nw, e_w);
        exp_d.push_back(e_rd); exp_e.push_back(e_err);
        nacc++; idx++;
        if (idx < 3) presentar(bq_we[idx], bq_tam[idx], 0, bq_dir[idx], bq_dat[idx]);
        else bus.req_valid = 1'b0;
      end
      @(negedge clk);
      if (bus.resp_valid) begin
        if (exp_d.size() == 0) chk("b2b:spurious", 1, 0);
        else begin
          chk("b2b:dato", bus.resp_dato, exp_d.pop_front());
          chk("b2b:err", 32'(bus.resp_err), 32'(exp_e.pop_front()));
        end
        nresp++;
      end
    end
    bus.req_valid = 1'b0;
    chk("b2b:nresp", nresp, 3);
    chk("b2b:nacc", nacc, 3);
    repeat (4) begin
      @(negedge clk);
      chk("b2b:extra", bus.resp_valid, 0);
    end

    for (int n = 0; n < 60; n++) begin
      tam = ($urandom_range(0, 9) == 0) ? TAM_RESERVADO : 2'($urandom_range(0, 2));
      dir = {24'b0, 6'($urandom), 2'($urandom)};
      if ($urandom_range(0, 1) == 1) dir[1:0] = 2'b00;
      if ($urandom_range(0, 11) == 0) dir = $urandom;
      hacer("rnd", 1'($urandom), tam, 1'($urandom), dir, $urandom);
    end

    chk("never_rd_and_wr", 32'(ambos), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectores, fallos);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
